fuel_pump_lock: RTL and testbench
=================================

Name: fuel_pump_lock

Overview:
- Parametrised successor of the single-switch fuel pump interlock for the vehicle anti-theft system.
- The pump is enabled only after ignition is on and the driver presses the brake with an SW_WIDTH-bit hidden code set on the dash switches, all within a timed entry window.
- Wrong codes are counted. Too many failures, or a window timeout, force a timed lockout that ignores ignition.

Parameters:
- SW_WIDTH, 4: width of hidden switch bank (>=1).
- UNLOCK_CODE, 4'b1010: secret code, SW_WIDTH bits.
- MAX_TRIES, 3: failed attempts that trigger lockout (>=1).
- WINDOW_CYCLES, 16: cycles allowed in ARMED before timeout (>=2).
- LOCKOUT_CYCLES, 64: cycles spent in LOCKOUT (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- brake  in  1  brake pedal, level.
- hidden_sw  in  SW_WIDTH  hidden switch bank.
- ignition  in  1  ignition key, level.
- fuel_pump  out  1  pump enable, registered.
- locked_out  out  1  high while in LOCKOUT, registered.
- fail_count  out  $clog2(MAX_TRIES+1)  current failed-attempt count.

Behaviour:
- States: OFF, ARMED, RUN, LOCKOUT. Encoding is free.
- Reset (reset=0, asynchronous) forces:
  - state=OFF;
  - window counter, lockout counter and fail_count = 0;
  - brake_q=0;
  - fuel_pump=0, locked_out=0.
- This applies mid-operation as well, including from RUN or LOCKOUT.
- Brake edge: brake_q registers brake every cycle in every state. attempt = brake & ~brake_q & (state==ARMED).
  - A brake already held when ARMED is entered is not an attempt; the driver must release and press again.
- Transitions:
  - OFF: ignition=1 -> ARMED next cycle, window counter cleared to 0. Otherwise stay in OFF.
  - ARMED, priority order:
    1. ignition=0 -> OFF. Any brake edge in that cycle is not counted.
    2. attempt with hidden_sw==UNLOCK_CODE -> RUN; fail_count cleared.
    3. attempt with mismatch and fail_count==MAX_TRIES-1 -> LOCKOUT; fail_count set to MAX_TRIES.
    4. attempt with mismatch otherwise -> stay ARMED; fail_count+1; window counter keeps running.
    5. window counter==WINDOW_CYCLES-1 -> LOCKOUT (timeout).
    6. Otherwise stay in ARMED; window counter+1.
  - A matching attempt in the same cycle as the timeout wins: go to RUN.
  - RUN: ignition=0 -> OFF. Otherwise stay in RUN. brake and hidden_sw are ignored.
  - LOCKOUT: ignition, brake and hidden_sw are all ignored. Lockout counter increments each cycle.
    - At count LOCKOUT_CYCLES-1 -> OFF; fail_count cleared; lockout counter cleared.
    - If ignition is still 1, OFF moves to ARMED on the following cycle.
- fail_count handling:
  - Cleared only by reset, by a successful unlock, or by lockout expiry.
  - Not cleared by cycling ignition, so the code cannot be brute-forced by toggling the key.
  - Saturates at MAX_TRIES.
- Outputs:
  - fuel_pump=1 exactly while state==RUN.
  - locked_out=1 exactly while state==LOCKOUT.
  - Both are derived from the registered state, with no combinational path from inputs.
  - Latency from a matching brake edge to fuel_pump=1 is 1 clock.
  - Latency from ignition falling in RUN to fuel_pump=0 is 1 clock.
- Window counter width: $clog2(WINDOW_CYCLES). Lockout counter width: $clog2(LOCKOUT_CYCLES+1). No counter wraps.

Optional Feature:
- Macro: FUEL_PUMP_LOCK_ALARM_EN.
- When defined:
  - Extra output port `alarm` (out, 1 bit), registered, reset 0.
  - `alarm` toggles every 4 clocks while in LOCKOUT, starting at 1 on the first LOCKOUT cycle.
  - `alarm` is forced 0 in every other state.
- When undefined:
  - No `alarm` port and no toggle logic.
  - All other behaviour is identical.

Test Plan:
1. Reset=0 mid-RUN -> fuel_pump, locked_out and fail_count go to 0 immediately (asynchronously); state is OFF after release.
2. ignition=1, then 3 cycles later hidden_sw=4'b1010 with brake 0->1 -> fuel_pump=1 one clock after the edge; then ignition=0 -> fuel_pump=0 one clock later.
3. ignition=1 with brake held high from before ARMED and correct code -> no unlock. Release then press brake -> unlock.
4. Three brake edges with hidden_sw=4'b0000:
   - fail_count goes 1, 2, 3 and locked_out=1 after the third edge;
   - then a correct code plus brake edge gives no unlock for 64 cycles;
   - the block returns to OFF then ARMED with fail_count=0.
5. Two wrong attempts, ignition toggled 1->0->1, then one wrong attempt -> LOCKOUT. fail_count survives the ignition cycling.
6. ignition=1 with no brake activity for 16 cycles -> locked_out=1 at cycle 16. A correct-code edge exactly at cycle 15 instead -> RUN. With FUEL_PUMP_LOCK_ALARM_EN, alarm toggles with period 8 during lockout.

Source files
------------

// File: rtl/fuel_pump_lock.sv
// Fuel pump anti-theft interlock: brake edge plus hidden code inside a timed window enables the pump.
// Optional FUEL_PUMP_LOCK_ALARM_EN adds an alarm output that blinks while locked out.
module fuel_pump_lock #(
    parameter int unsigned          SW_WIDTH       = 4,
    parameter logic [SW_WIDTH-1:0]  UNLOCK_CODE    = 4'b1010,
    parameter int unsigned          MAX_TRIES      = 3,
    parameter int unsigned          WINDOW_CYCLES  = 16,
    parameter int unsigned          LOCKOUT_CYCLES = 64
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             brake,
    input  logic [SW_WIDTH-1:0]              hidden_sw,
    input  logic                             ignition,
    output logic                             fuel_pump,
    output logic                             locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
`ifdef FUEL_PUMP_LOCK_ALARM_EN
    ,
    output logic                             alarm
`endif
);

    localparam int unsigned WC_W = $clog2(WINDOW_CYCLES);
    localparam int unsigned LC_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned FC_W = $clog2(MAX_TRIES + 1);

    localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WINDOW_CYCLES - 1);
    localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_MAX    = FC_W'(MAX_TRIES);
    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {S_OFF, S_ARMED, S_RUN, S_LOCKOUT} state_t;

    state_t          state, state_n;
    logic [WC_W-1:0] win_cnt, win_n;
    logic [LC_W-1:0] lock_cnt, lock_n;
    logic [FC_W-1:0] fail_n;
    logic            brake_q;
    logic            attempt;
    logic            match;

    // Only a fresh press counts; a pedal held across arming must be released first.
    assign attempt = brake & ~brake_q & (state == S_ARMED);
    assign match   = (hidden_sw == UNLOCK_CODE);

    always_comb begin
        state_n = state;
        win_n   = win_cnt;
        lock_n  = lock_cnt;
        fail_n  = fail_count;
        case (state)
            S_OFF: begin
                if (ignition) begin
                    state_n = S_ARMED;
                    win_n   = '0;
                end
            end
            S_ARMED: begin
                if (!ignition) begin
                    state_n = S_OFF;
                end else if (attempt && match) begin
                    state_n = S_RUN;
                    fail_n  = '0;
                end else if (attempt && fail_count >= FC_LAST) begin
                    state_n = S_LOCKOUT;
                    fail_n  = FC_MAX;
                end else if (attempt) begin
                    fail_n = fail_count + 1'b1;
                    // Hold at the last count so the timeout still fires next cycle.
                    if (win_cnt != WIN_LAST) win_n = win_cnt + 1'b1;
                end else if (win_cnt == WIN_LAST) begin
                    state_n = S_LOCKOUT;
                end else begin
                    win_n = win_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!ignition) state_n = S_OFF;
            end
            S_LOCKOUT: begin
                if (lock_cnt == LOCK_LAST) begin
                    state_n = S_OFF;
                    fail_n  = '0;
                    lock_n  = '0;
                end else begin
                    lock_n = lock_cnt + 1'b1;
                end
            end
            default: state_n = S_OFF;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_OFF;
            win_cnt    <= '0;
            lock_cnt   <= '0;
            fail_count <= '0;
            brake_q    <= 1'b0;
            fuel_pump  <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_n;
            win_cnt    <= win_n;
            lock_cnt   <= lock_n;
            fail_count <= fail_n;
            brake_q    <= brake;
            fuel_pump  <= (state_n == S_RUN);
            locked_out <= (state_n == S_LOCKOUT);
        end
    end

`ifdef FUEL_PUMP_LOCK_ALARM_EN
    logic [1:0] alarm_ph;

    // Alarm starts high on lockout entry and flips every fourth lockout cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alarm    <= 1'b0;
            alarm_ph <= '0;
        end else if (state_n == S_LOCKOUT) begin
            if (state != S_LOCKOUT) begin
                alarm    <= 1'b1;
                alarm_ph <= '0;
            end else begin
                alarm_ph <= alarm_ph + 1'b1;
                if (alarm_ph == 2'd3) alarm <= ~alarm;
            end
        end else begin
            alarm    <= 1'b0;
            alarm_ph <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fuel_pump_lock.sv
// Directed bench for fuel_pump_lock: unlock, held brake, wrong-code lockout, ignition cycling, timeout, reset.
module tb_fuel_pump_lock;

    logic       clock;
    logic       reset;
    logic       brake;
    logic [3:0] hidden_sw;
    logic       ignition;
    logic       fuel_pump;
    logic       locked_out;
    logic [1:0] fail_count;
`ifdef FUEL_PUMP_LOCK_ALARM_EN
    logic       alarm;
`endif

    int checks   = 0;
    int failures = 0;

    fuel_pump_lock dut (
        .clock      (clock),
        .reset      (reset),
        .brake      (brake),
        .hidden_sw  (hidden_sw),
        .ignition   (ignition),
        .fuel_pump  (fuel_pump),
        .locked_out (locked_out),
        .fail_count (fail_count)
`ifdef FUEL_PUMP_LOCK_ALARM_EN
        ,
        .alarm      (alarm)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic fp, input logic lo, input logic [1:0] fc);
        chk({tag, ".fuel_pump"}, 32'(fuel_pump), 32'(fp));
        chk({tag, ".locked_out"}, 32'(locked_out), 32'(lo));
        chk({tag, ".fail_count"}, 32'(fail_count), 32'(fc));
    endtask

    initial begin
        reset = 1'b0; brake = 1'b0; hidden_sw = 4'h0; ignition = 1'b0;
        #2;
        chk_out("reset_state", 1'b0, 1'b0, 2'd0);
`ifdef FUEL_PUMP_LOCK_ALARM_EN
        chk("reset_alarm", 32'(alarm), 32'd0);
`endif
        tick(); tick();
        reset = 1'b1;
        tick();
        chk_out("idle_off", 1'b0, 1'b0, 2'd0);

        // Basic unlock, three cycles into the window
        ignition = 1'b1;
        tick(); tick(); tick(); tick();
        hidden_sw = 4'b1010; brake = 1'b1;
        chk_out("unlock_pre", 1'b0, 1'b0, 2'd0);
        tick();
        chk_out("unlock_post", 1'b1, 1'b0, 2'd0);
        ignition = 1'b0; brake = 1'b0;
        tick();
        chk_out("ign_off", 1'b0, 1'b0, 2'd0);

        // Brake held across arming is not an attempt
        brake = 1'b1;
        tick();
        ignition = 1'b1;
        tick(); tick(); tick();
        chk_out("held_brake", 1'b0, 1'b0, 2'd0);
        brake = 1'b0;
        tick();
        brake = 1'b1;
        tick();
        chk_out("held_repress", 1'b1, 1'b0, 2'd0);
        ignition = 1'b0; brake = 1'b0;
        tick();

        // Three wrong codes -> lockout, then expiry
        hidden_sw = 4'b0000; ignition = 1'b1;
        tick();
        brake = 1'b1; tick();
        chk_out("wrong1", 1'b0, 1'b0, 2'd1);
        brake = 1'b0; tick();
        brake = 1'b1; tick();
        chk_out("wrong2", 1'b0, 1'b0, 2'd2);
        brake = 1'b0; tick();
        brake = 1'b1; tick();
        chk_out("wrong3_lock", 1'b0, 1'b1, 2'd3);
`ifdef FUEL_PUMP_LOCK_ALARM_EN
        chk("alarm_j0", 32'(alarm), 32'd1);
`endif
        hidden_sw = 4'b1010; brake = 1'b0;
        tick();
        brake = 1'b1;
        tick();
        chk_out("lock_ignores_code", 1'b0, 1'b1, 2'd3);
`ifdef FUEL_PUMP_LOCK_ALARM_EN
        chk("alarm_j2", 32'(alarm), 32'd1);
`endif
        for (int j = 3; j <= 63; j++) begin
            tick();
            chk("lock_hold", 32'(locked_out), 32'd1);
`ifdef FUEL_PUMP_LOCK_ALARM_EN
            chk("alarm_blink", 32'(alarm), 32'(((j >> 2) & 1) == 0));
`endif
        end
        chk_out("lock_last", 1'b0, 1'b1, 2'd3);
        tick();
        chk_out("lock_expire", 1'b0, 1'b0, 2'd0);
`ifdef FUEL_PUMP_LOCK_ALARM_EN
        chk("alarm_off", 32'(alarm), 32'd0);
`endif
        tick();
        brake = 1'b0; tick();
        brake = 1'b1; tick();
        chk_out("rearm_unlock", 1'b1, 1'b0, 2'd0);
        ignition = 1'b0; brake = 1'b0;
        tick();

        // fail_count survives ignition cycling
        hidden_sw = 4'b0000; ignition = 1'b1;
        tick();
        brake = 1'b1; tick();
        brake = 1'b0; tick();
        brake = 1'b1; tick();
        chk_out("cyc_wrong2", 1'b0, 1'b0, 2'd2);
        brake = 1'b0; ignition = 1'b0;
        tick();
        chk_out("cyc_off", 1'b0, 1'b0, 2'd2);
        ignition = 1'b1;
        tick();
        brake = 1'b1; tick();
        chk_out("cyc_lock", 1'b0, 1'b1, 2'd3);

        // Asynchronous reset out of lockout
        reset = 1'b0;
        #1;
        chk_out("rst_from_lock", 1'b0, 1'b0, 2'd0);
        brake = 1'b0;
        tick();
        reset = 1'b1;

        // Window timeout: 16 idle ARMED cycles
        tick();
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("win_wait", 32'(locked_out), 32'd0);
        end
        tick();
        chk_out("win_timeout", 1'b0, 1'b1, 2'd0);
        reset = 1'b0; #1; tick();
        reset = 1'b1;

        // Matching attempt on the timeout cycle wins
        hidden_sw = 4'b1010;
        tick();
        for (int k = 1; k <= 15; k++) tick();
        brake = 1'b1;
        tick();
        chk_out("win_edge_unlock", 1'b1, 1'b0, 2'd0);

        // Asynchronous reset out of RUN
        tick();
        reset = 1'b0;
        #1;
        chk_out("rst_from_run", 1'b0, 1'b0, 2'd0);
        ignition = 1'b0; brake = 1'b0;
        tick();
        reset = 1'b1;
        tick(); tick();
        chk_out("post_rst_off", 1'b0, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
